// File: rtl/rotate_amount_finder_16.sv
// Sequential search for the smallest right-rotation r (0..15) that maps a onto y.
// Optional macro ROTATE_FINDER_MIN_DIST_EN reports found results in the shorter direction.
module rotate_amount_finder_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [3:0]  amt,
    output logic        lr
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cand_q, cand_d;
    logic [15:0] targ_q, targ_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic [3:0]  amt_q, amt_d;
    logic        lr_q, lr_d;

    // Maps the matching right-rotation count to {lr, amt}.
    function automatic logic [4:0] report(input logic [3:0] r);
`ifdef ROTATE_FINDER_MIN_DIST_EN
        if (r > 4'd8) begin
            report = {1'b1, 4'd0 - r};
        end else begin
            report = {1'b0, r};
        end
`else
        report = {1'b0, r};
`endif
    endfunction

    // Next-state logic: one candidate compare per SEARCH cycle.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        targ_d  = targ_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        found_d = found_q;
        amt_d   = amt_q;
        lr_d    = lr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cand_d  = a;
                    targ_d  = y;
                    cnt_d   = 4'd0;
                    state_d = SEARCH;
                end else begin
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                if (cand_q == targ_q) begin
                    done_d        = 1'b1;
                    found_d       = 1'b1;
                    {lr_d, amt_d} = report(cnt_q);
                    state_d       = IDLE;
                end else if (cnt_q == 4'd15) begin
                    // All sixteen rotations tried; stop rather than wrap the counter.
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    amt_d   = 4'd0;
                    lr_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cand_d = {cand_q[0], cand_q[15:1]};
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= 16'd0;
            targ_q  <= 16'd0;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            amt_q   <= 4'd0;
            lr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            targ_q  <= targ_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            found_q <= found_d;
            amt_q   <= amt_d;
            lr_q    <= lr_d;
        end
    end

    assign busy  = (state_q == SEARCH);
    assign done  = done_q;
    assign found = found_q;
    assign amt   = amt_q;
    assign lr    = lr_q;

endmodule

// File: tb/tb_rotate_amount_finder_16.sv
// Directed bench for rotate_amount_finder_16 with a queue-based scoreboard of expected results.
module tb_rotate_amount_finder_16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'd0;
    logic [15:0] y = 16'd0;
    logic        busy, done, found, lr;
    logic [3:0]  amt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    typedef struct {
        logic       found;
        logic [3:0] amt;
        logic       lr;
        int         lat;
    } exp_t;
    exp_t sb[$];

    rotate_amount_finder_16 dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .y(y),
        .busy(busy), .done(done), .found(found), .amt(amt), .lr(lr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] ty);
        exp_t e;
        logic [15:0] rot;
        e = '{found: 1'b0, amt: 4'd0, lr: 1'b0, lat: 16};
        rot = ta;
        for (int r = 0; r < 16; r++) begin
            if (!e.found && rot == ty) begin
                e.found = 1'b1;
                e.lat   = r + 1;
`ifdef ROTATE_FINDER_MIN_DIST_EN
                if (r > 8) begin
                    e.lr  = 1'b1;
                    e.amt = 4'(16 - r);
                end else begin
                    e.amt = 4'(r);
                end
`else
                e.amt = 4'(r);
`endif
            end
            rot = {rot[0], rot[15:1]};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive a start pulse (optionally in the current cycle) and record the expectation.
    task automatic issue(input logic [15:0] ta, input logic [15:0] ty, input bit now, input bit push);
        if (!now) @(negedge clk);
        a = ta;
        y = ty;
        start = 1'b1;
        if (push) sb.push_back(model(ta, ty));
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        check("busy_after_start", {15'd0, busy}, 16'd1);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            check("busy_during_search", {15'd0, busy}, 16'd1);
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, "_done_seen"}, {15'd0, done}, 16'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, 16'(cyc - start_cyc), 16'(e.lat));
            check({tag, "_found"}, {15'd0, found}, {15'd0, e.found});
            check({tag, "_amt"}, {12'd0, amt}, {12'd0, e.amt});
            check({tag, "_lr"}, {15'd0, lr}, {15'd0, e.lr});
            check({tag, "_busy_at_done"}, {15'd0, busy}, 16'd0);
        end
    endtask

    task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] ty);
        issue(ta, ty, 1'b0, 1'b1);
        wait_done(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        #2;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_found", {15'd0, found}, 16'd0);
        check("rst_amt", {12'd0, amt}, 16'd0);
        check("rst_lr", {15'd0, lr}, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run("r13", 16'h0001, 16'h0008);
        run("same", 16'h1234, 16'h1234);
        run("ones", 16'hFFFF, 16'hFFFF);
        run("zeros", 16'h0000, 16'h0000);
        run("r1", 16'h8000, 16'h4000);
        run("tie8", 16'h00FF, 16'hFF00);
        run("notfound", 16'h0001, 16'h0003);

        // Start and input changes while busy must not disturb the running search.
        issue(16'h0001, 16'h0008, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a = 16'h5555;
        y = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        a = 16'hAAAA;
        wait_done("ignore");
        repeat (4) begin
            @(posedge clk);
            #1;
            check("ignore_single_done", {15'd0, done}, 16'd0);
        end

        // Back-to-back: second start issued in the done cycle of the first.
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done("b2b_first");
        issue(16'h00F0, 16'h0F00, 1'b1, 1'b1);
        wait_done("b2b_second");

        // Reset five clocks into a search aborts it and clears the results.
        issue(16'h0001, 16'h0003, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_found", {15'd0, found}, 16'd0);
        check("abort_amt", {12'd0, amt}, 16'd0);
        check("abort_lr", {15'd0, lr}, 16'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {15'd0, done}, 16'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        run("post_reset", 16'h0003, 16'h8001);

        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
